stopwatch_ctrl: RTL

- Control sequencer for the stopwatch BCD time datapath. Turns debounced button levels and optional CPU commands into run/stop/lap/clear control.
- Generates the millisecond count-enable tick, the counter clear pulse and the display hold (lap) control.
- Sits between the debouncers / CPU register interface and the BCD counter chain plus display latch.

---
 rtl/stopwatch_ctrl.sv | 127 ++++++++++++
 1 files changed

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control sequencer: turns button levels and CPU commands into
// run/stop/lap/clear control, the ms count tick and the display hold pulse.
module stopwatch_ctrl #(
    parameter int MSPN = 24000,
    parameter int CW   = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       b_run,
    input  logic       b_clr,
    input  logic       b_lap,
    input  logic       cmd_vld,
    input  logic [1:0] cmd,
    output logic       cnt_tick,
    output logic       cnt_clr,
    output logic       hld_load,
    output logic       disp_sel,
    output logic       s_run,
    output logic       s_hld,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, RUN, LAP, STOP} state_t;

    localparam logic [CW-1:0] PRE_MAX = CW'(MSPN - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] pre_q, pre_d;
    logic          b_run_q, b_clr_q, b_lap_q;
    logic          arm_q;
    logic          cnt_tick_q, cnt_tick_d;
    logic          cnt_clr_q, cnt_clr_d;
    logic          hld_load_q, hld_load_d;
    logic          ev_run, ev_clr, ev_lap;
    logic          cnt_en;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pre_q      <= '0;
            b_run_q    <= 1'b0;
            b_clr_q    <= 1'b0;
            b_lap_q    <= 1'b0;
            arm_q      <= 1'b0;
            cnt_tick_q <= 1'b0;
            cnt_clr_q  <= 1'b0;
            hld_load_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pre_q      <= pre_d;
            b_run_q    <= b_run;
            b_clr_q    <= b_clr;
            b_lap_q    <= b_lap;
            arm_q      <= 1'b1;
            cnt_tick_q <= cnt_tick_d;
            cnt_clr_q  <= cnt_clr_d;
            hld_load_q <= hld_load_d;
        end
    end

    // Button edges are masked for the first cycle after reset so a level held
    // through reset only loads b_*_q instead of firing an event.
    always_comb begin
        ev_run = (b_run & ~b_run_q & arm_q) | (cmd_vld & (cmd == 2'd1));
        ev_clr = (b_clr & ~b_clr_q & arm_q) | (cmd_vld & (cmd == 2'd2));
        ev_lap = (b_lap & ~b_lap_q & arm_q) | (cmd_vld & (cmd == 2'd3));
    end

    always_comb begin
        state_d    = state_q;
        cnt_clr_d  = 1'b0;
        hld_load_d = 1'b0;
        unique case (state_q)
            IDLE, STOP: begin
                if (ev_clr) begin
                    state_d   = IDLE;
                    cnt_clr_d = 1'b1;
                end else if (ev_run) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (ev_run) begin
                    state_d = STOP;
                end else if (ev_lap) begin
                    state_d    = LAP;
                    hld_load_d = 1'b1;
                end
            end
            LAP: begin
                if (ev_run) state_d = STOP;
                else if (ev_lap) state_d = RUN;
            end
            default: state_d = IDLE;
        endcase
    end

    // Count only while running now and next cycle: the stopping cycle neither
    // advances the fraction nor ticks, so the fraction resumes intact.
    always_comb begin
        cnt_en     = ((state_q == RUN) || (state_q == LAP)) &&
                     ((state_d == RUN) || (state_d == LAP));
        pre_d      = pre_q;
        cnt_tick_d = 1'b0;
        if (cnt_clr_d) begin
            pre_d = '0;
        end else if (cnt_en) begin
            if (pre_q == PRE_MAX) begin
                pre_d      = '0;
                cnt_tick_d = 1'b1;
            end else begin
                pre_d = pre_q + 1'b1;
            end
        end
    end

    always_comb begin
        cnt_tick = cnt_tick_q;
        cnt_clr  = cnt_clr_q;
        hld_load = hld_load_q;
        s_run    = (state_q == RUN) || (state_q == LAP);
        s_hld    = (state_q == LAP);
        disp_sel = (state_q == LAP);
        busy     = (state_q != IDLE);
    end

endmodule
